// File: rtl/barrel_pkg.sv
// Shared helpers for the barrel un-shifter pipeline.
//   stage_cnt(n) : number of log-stages for an n-bit rotate ($clog2(n))
//   is_pow2(n)   : elaboration-time sanity check on the data width
//   rotl(d,a,n)  : behavioural rotate-left of the low n bits of d by a mod n
package barrel_pkg;

    localparam int unsigned MAX_N = 64;

    function automatic int unsigned stage_cnt(input int unsigned n);
        return $clog2(n);
    endfunction

    function automatic bit is_pow2(input int unsigned n);
        return (n != 0) && ((n & (n - 1)) == 0);
    endfunction

    function automatic logic [63:0] rotl(input logic [63:0] data,
                                         input int unsigned amt,
                                         input int unsigned n);
        logic [63:0] mask;
        logic [63:0] r;
        int unsigned a;
        mask = (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
        a    = amt % n;
        r    = data & mask;
        if (a != 0)
            r = ((r << a) | (r >> (n - a))) & mask;
        return r;
    endfunction

endpackage

// File: rtl/nbit_barrel_unshifter_pipe_stage.sv
// barrel_rot_stage: one registered log-stage of the rotate-left pipeline.
// Rotates left by 2**K when amount bit K is set, and forms a one-deep
// valid/ready slice: it loads whenever it is empty or downstream is taking
// its current word.
//   clk_i/reset_i           : clock, synchronous active-high reset
//   up_valid_i/up_ready_o   : upstream handshake (up_ready_o = load)
//   up_data_i/up_amt_i      : word and effective amount from upstream
//   dn_valid_o/dn_ready_i   : downstream handshake
//   dn_data_o/dn_amt_o      : registered word and amount
module barrel_rot_stage
    import barrel_pkg::*;
#(
    parameter int N  = 8,
    parameter int K  = 0,
    parameter int AW = 3
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          up_valid_i,
    output logic          up_ready_o,
    input  logic [N-1:0]  up_data_i,
    input  logic [AW-1:0] up_amt_i,
    output logic          dn_valid_o,
    input  logic          dn_ready_i,
    output logic [N-1:0]  dn_data_o,
    output logic [AW-1:0] dn_amt_o
);
    localparam int SH = 2 ** K;

    logic          valid_q;
    logic [N-1:0]  data_q, data_d;
    logic [AW-1:0] amt_q;
    logic          load;

    // An empty slot always fills, so bubbles collapse even while stalled.
    assign load       = !valid_q || dn_ready_i;
    assign up_ready_o = load;

    assign data_d = up_amt_i[K] ? {up_data_i[N-SH-1:0], up_data_i[N-1:N-SH]}
                                : up_data_i;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
        end else if (load) begin
            valid_q <= up_valid_i;
            data_q  <= data_d;
            amt_q   <= up_amt_i;
        end
    end

    assign dn_valid_o = valid_q;
    assign dn_data_o  = data_q;
    assign dn_amt_o   = amt_q;

endmodule

// File: rtl/nbit_barrel_unshifter_pipe.sv
// nbit_barrel_unshifter_pipe: pipelined rotate-left by (shift_amt mod N),
// undoing a barrel rotate-right by the same amount. One log-stage per cycle,
// latency $clog2(N), one word per clock when downstream is ready.
//   clk, reset           : clock, synchronous active-high reset
//   in_valid/in_ready    : input handshake; in_ready never depends on in_valid
//   in_data/shift_amt    : word and rotate amount (low $clog2(N) bits used)
//   out_valid/out_ready  : output handshake
//   out_data             : rotl(in_data, shift_amt mod N)
//   busy                 : any stage holds a valid word
module nbit_barrel_unshifter_pipe
    import barrel_pkg::*;
#(
    parameter int N     = 8,
    parameter int AMT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_data,
    input  logic [AMT_W-1:0] shift_amt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out_data,
    output logic             busy
);
    localparam int S = stage_cnt(N);

    if (!is_pow2(N) || N < 2) begin : g_bad_n
        $error("nbit_barrel_unshifter_pipe: N must be a power of two >= 2");
    end
    if (AMT_W < S) begin : g_bad_amt
        $error("nbit_barrel_unshifter_pipe: AMT_W too narrow for N");
    end

    // Index 0 is the input side; index k+1 is the output of stage k.
    logic [S:0]          vld;
    logic [S:0]          rdy;
    logic [S:0][N-1:0]   dat;
    logic [S:0][S-1:0]   amt;

    assign vld[0] = in_valid;
    assign dat[0] = in_data;
    assign amt[0] = shift_amt[S-1:0];
    assign rdy[S] = out_ready;

    for (genvar k = 0; k < S; k++) begin : g_stage
        barrel_rot_stage #(.N(N), .K(k), .AW(S)) u_stage (
            .clk_i      (clk),
            .reset_i    (reset),
            .up_valid_i (vld[k]),
            .up_ready_o (rdy[k]),
            .up_data_i  (dat[k]),
            .up_amt_i   (amt[k]),
            .dn_valid_o (vld[k+1]),
            .dn_ready_i (rdy[k+1]),
            .dn_data_o  (dat[k+1]),
            .dn_amt_o   (amt[k+1])
        );
    end

    assign in_ready  = rdy[0];
    assign out_valid = vld[S];
    assign out_data  = dat[S];
    assign busy      = |vld[S:1];

    // Amount bits above log2(N) and the fully consumed amount at the tail
    // carry no information.
    logic unused_amt;
    if (AMT_W > S) begin : g_unused_hi
        assign unused_amt = ^{shift_amt[AMT_W-1:S], amt[S]};
    end else begin : g_unused_lo
        assign unused_amt = ^amt[S];
    end

endmodule

// File: tb/tb_nbit_barrel_unshifter_pipe.sv
module tb_nbit_barrel_unshifter_pipe;
    import barrel_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;

    logic        iv   [3];
    logic        irdy [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        bsy  [3];
    logic [31:0] din  [3];
    logic [7:0]  ain  [3];
    logic [31:0] dout [3];
    logic [31:0] exp_in [3];
    logic        lat_on;
    logic [7:0]  d8;
    logic [15:0] d16;
    logic [31:0] d32;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nbit_barrel_unshifter_pipe #(.N(8), .AMT_W(8)) u8 (
        .clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_data(din[0][7:0]), .shift_amt(ain[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(d8), .busy(bsy[0]));
    nbit_barrel_unshifter_pipe #(.N(16), .AMT_W(8)) u16 (
        .clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_data(din[1][15:0]), .shift_amt(ain[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(d16), .busy(bsy[1]));
    nbit_barrel_unshifter_pipe #(.N(32), .AMT_W(8)) u32 (
        .clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_data(din[2]), .shift_amt(ain[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(d32), .busy(bsy[2]));

    always_comb begin
        dout[0] = {24'h0, d8};
        dout[1] = {16'h0, d16};
        dout[2] = d32;
    end

    function automatic int stages_of(input int sel);
        return 3 + sel;
    endfunction

    function automatic int width_of(input int sel);
        return 8 << sel;
    endfunction

    // Reference upstream shifter: rotate-right by amt mod n.
    function automatic logic [31:0] rotr(input logic [31:0] d, input int unsigned a,
                                         input int unsigned n);
        logic [63:0] x, m, r;
        int unsigned s;
        s = a % n;
        m = (64'd1 << n) - 64'd1;
        x = {32'h0, d} & m;
        r = (s == 0) ? x : (((x >> s) | (x << (n - s))) & m);
        return r[31:0];
    endfunction

    typedef struct {
        int          sel;
        logic [31:0] exp;
        int          acc;
        bit          lat;
    } sb_t;
    sb_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Scoreboard monitor: pops on output transfer, pushes on accept.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 3; i++) begin
                if (ov[i] && ordy[i]) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL unexpected_out: inst %0d got %h expected none", i, dout[i]);
                    end else begin
                        sb_t e;
                        e = sb.pop_front();
                        if (e.sel != i || dout[i] !== e.exp) begin
                            fails++;
                            $display("FAIL sb_data: inst %0d got %h expected inst %0d data %h",
                                     i, dout[i], e.sel, e.exp);
                        end
                        if (e.lat) begin
                            tests++;
                            if (cyc - e.acc != stages_of(i)) begin
                                fails++;
                                $display("FAIL latency: inst %0d got %0d expected %0d",
                                         i, cyc - e.acc, stages_of(i));
                            end
                        end
                    end
                end
            end
            for (int i = 0; i < 3; i++)
                if (iv[i] && irdy[i])
                    sb.push_back('{sel: i, exp: exp_in[i], acc: cyc, lat: lat_on});
        end
    end

    // Present one word and hold it until accepted; returns on the accept negedge.
    task automatic drive_one(input int sel, input logic [31:0] d, input logic [7:0] a,
                             input logic [31:0] e, input bit lat, input int limit);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        iv[sel] = 1'b1; din[sel] = d; ain[sel] = a; exp_in[sel] = e; lat_on = lat;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (irdy[sel]) begin ok = 1; break; end
        end
        if (!ok) begin
            tests++; fails++;
            $display("FAIL accept_timeout: inst %0d got no accept expected accept", sel);
        end
    endtask

    task automatic idle(input int sel);
        @(posedge clk); #1;
        iv[sel] = 1'b0;
    endtask

    task automatic drain(input int limit);
        int k;
        k = 0;
        while (sb.size() != 0 && k < limit) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            tests++; fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
        end
    endtask

    typedef struct {
        int          sel;
        logic [31:0] d;
        logic [7:0]  amt;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[10];

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 0; ordy[i] = 1; din[i] = 0; ain[i] = 0; exp_in[i] = 0;
        end
        lat_on = 0;

        vecs[0] = '{0, 32'hB4,       8'd3,  32'hA5};
        vecs[1] = '{0, 32'hB4,       8'd11, 32'hA5};
        vecs[2] = '{0, 32'hB4,       8'd8,  32'hB4};
        vecs[3] = '{0, 32'h81,       8'd1,  32'h03};
        vecs[4] = '{0, 32'h01,       8'd7,  32'h80};
        vecs[5] = '{1, 32'h1234,     8'd4,  32'h2341};
        vecs[6] = '{1, 32'h8001,     8'd15, 32'hC000};
        vecs[7] = '{2, 32'h80000001, 8'd1,  32'h00000003};
        vecs[8] = '{2, 32'h12345678, 8'd8,  32'h34567812};
        vecs[9].sel = 1; vecs[9].d = 32'h0000_9ABC; vecs[9].amt = 8'd37;
        vecs[9].exp = 32'(rotl(64'h9ABC, 37, 16));

        repeat (2) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_out_valid%0d", i), {31'h0, ov[i]}, 32'h0);
            chk($sformatf("rst_busy%0d", i), {31'h0, bsy[i]}, 32'h0);
            chk($sformatf("rst_in_ready%0d", i), {31'h0, irdy[i]}, 32'h1);
            chk($sformatf("rst_out_data%0d", i), dout[i], 32'h0);
        end

        // Table vectors, one at a time, with latency checked.
        for (int v = 0; v < 10; v++) begin
            drive_one(vecs[v].sel, vecs[v].d, vecs[v].amt, vecs[v].exp, 1'b1, 50);
            idle(vecs[v].sel);
            drain(50);
        end

        // Backpressure on N=8.
        ordy[0] = 0;
        drive_one(0, 32'h01, 8'd1, 32'h02, 1'b0, 50);
        drive_one(0, 32'h02, 8'd1, 32'h04, 1'b0, 50);
        drive_one(0, 32'h04, 8'd1, 32'h08, 1'b0, 50);
        @(posedge clk); #1;
        din[0] = 32'h10; ain[0] = 8'd1; exp_in[0] = 32'h20;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", {31'h0, irdy[0]}, 32'h0);
            chk("bp_out_valid", {31'h0, ov[0]}, 32'h1);
            chk("bp_out_hold", dout[0], 32'h02);
            @(posedge clk); #1;
        end
        iv[0] = 0; ordy[0] = 1;
        @(negedge clk); chk("bp_first", {31'h0, ov[0]} << 8 | dout[0], 32'h102);
        @(negedge clk); chk("bp_second", {31'h0, ov[0]} << 8 | dout[0], 32'h104);
        @(negedge clk); chk("bp_third", {31'h0, ov[0]} << 8 | dout[0], 32'h108);
        chk("bp_busy_last", {31'h0, bsy[0]}, 32'h1);
        @(negedge clk);
        chk("bp_busy_done", {31'h0, bsy[0]}, 32'h0);
        chk("bp_valid_done", {31'h0, ov[0]}, 32'h0);
        drain(20);

        // Reset mid-stream with two words in flight.
        drive_one(0, 32'h11, 8'd2, 32'h44, 1'b0, 50);
        drive_one(0, 32'h22, 8'd2, 32'h88, 1'b0, 50);
        @(posedge clk); #1;
        iv[0] = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        sb.delete();
        @(negedge clk);
        chk("mid_rst_out_valid", {31'h0, ov[0]}, 32'h0);
        chk("mid_rst_busy", {31'h0, bsy[0]}, 32'h0);
        chk("mid_rst_in_ready", {31'h0, irdy[0]}, 32'h1);
        repeat (10) @(negedge clk);

        // Round trip: upstream rotate-right feeds the block, random backpressure.
        for (int sel = 0; sel < 3; sel++) begin
            bit done;
            done = 0;
            fork
                begin
                    for (int w = 0; w < 150; w++) begin
                        logic [31:0] d;
                        logic [7:0]  a;
                        d = $urandom;
                        if (sel < 2) d = d & ((32'd1 << width_of(sel)) - 32'd1);
                        a = 8'($urandom_range(0, 255));
                        if ($urandom_range(0, 3) == 0) idle(sel);
                        drive_one(sel, rotr(d, a, width_of(sel)), a, d, 1'b0, 200);
                    end
                    idle(sel);
                    done = 1;
                end
                begin
                    while (!done) begin
                        @(posedge clk); #1;
                        ordy[sel] = ($urandom_range(0, 3) != 0);
                    end
                    ordy[sel] = 1;
                end
            join
            drain(300);
            @(negedge clk);
            chk($sformatf("rt_busy_end%0d", sel), {31'h0, bsy[sel]}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
